// File: rtl/bram_pkg.sv
// bram_pkg: sizing helpers and the byte-merge function shared by the
// bram_sdp_flow slice (top and response FIFO).
package bram_pkg;

  // Widest data word the merge helper handles; callers size-cast in and out.
  localparam int MAX_DATA_W = 1024;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  // Counter wide enough to hold 0..depth inclusive.
  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Bytes with be=1 take new_word, the rest keep old_word.
  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bram_sdp_rsp_fifo.sv
// bram_sdp_rsp_fifo: DEPTH-entry response FIFO with wrap-around pointers.
// An empty FIFO passes a push straight to the output in the same cycle so a
// response is visible the cycle it leaves the read pipeline.
module bram_sdp_rsp_fifo
  import bram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = credit_w(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0]  count_d, count_q;
  logic              empty;
  logic              pop_fire;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty     = (count_q == '0);
  assign out_valid = !empty || push;
  assign out_data  = !empty ? mem_q[rd_ptr_q] : (push ? push_data : '0);
  assign pop_fire  = pop && out_valid;

  // Pointer and occupancy update; a bypassed push+pop moves both pointers
  always_comb begin
    wr_ptr_d = push     ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_fire ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop_fire) count_d = count_q + CNT_W'(1);
    else if (!push && pop_fire) count_d = count_q - CNT_W'(1);
  end

  // Control state, cleared asynchronously
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; no reset, output is gated by occupancy instead
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/bram_sdp_flow.sv
// bram_sdp_flow: simple-dual-port block RAM with byte-enable writes,
// 1- or 2-cycle read latency (OUT_REG), valid/ready read request and
// response ports, and credit-managed response buffering.
// Optional build macro BRAM_SDP_FWD_EN: forward same-address writes into
// read results (same cycle, and the following cycle when OUT_REG=1).
// Without it, collisions are strictly read-first.
module bram_sdp_flow
  import bram_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 9,
  parameter int NUM_ROWS  = 512,
  parameter int OUT_REG   = 0,
  parameter int RSP_DEPTH = OUT_REG + 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                rd_req_valid,
  output logic                rd_req_ready,
  input  logic [ADDR_W-1:0]   rd_req_addr,
  output logic                rd_rsp_valid,
  input  logic                rd_rsp_ready,
  output logic [DATA_W-1:0]   rd_rsp_data,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0]   wr_data
);
  localparam int BE_W     = be_w(DATA_W);
  localparam int CREDIT_W = credit_w(RSP_DEPTH);
  localparam int ROW_AW   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [ADDR_W:0]     ROWS_L  = (ADDR_W+1)'(NUM_ROWS);
  localparam logic [CREDIT_W-1:0] DEPTH_L = CREDIT_W'(RSP_DEPTH);

  logic [DATA_W-1:0]   mem [NUM_ROWS];
  logic [ROW_AW-1:0]   wr_idx, rd_idx;
  logic                wr_in_range;
  logic [DATA_W-1:0]   rd_word;

  logic                fire, pop;
  logic [CREDIT_W-1:0] credit_d, credit_q;

  logic                s1_valid_d, s1_valid_q;
  logic [DATA_W-1:0]   s1_data_d, s1_data_q;

  logic                push_valid;
  logic [DATA_W-1:0]   push_data;

  assign wr_idx      = wr_addr[ROW_AW-1:0];
  assign rd_idx      = rd_req_addr[ROW_AW-1:0];
  assign wr_in_range = ({1'b0, wr_addr} < ROWS_L);
  assign rd_word     = mem[rd_idx];

  assign rd_req_ready = (credit_q < DEPTH_L);
  assign fire         = rd_req_valid && rd_req_ready;
  assign pop          = rd_rsp_valid && rd_rsp_ready;

  // Byte-masked write port; out-of-range addresses are dropped
  always_ff @(posedge CLK) begin
    if (wr_en && wr_in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

`ifdef BRAM_SDP_FWD_EN
  logic wr_hit_rd;
  assign wr_hit_rd = wr_en && wr_in_range && (wr_addr == rd_req_addr);
`endif

  // Stage 1: array read on acceptance, optionally patched by a colliding write
  always_comb begin
    s1_valid_d = fire;
    s1_data_d  = s1_data_q;
    if (fire) begin
      s1_data_d = rd_word;
`ifdef BRAM_SDP_FWD_EN
      if (wr_hit_rd) begin
        s1_data_d = DATA_W'(byte_merge(MAX_DATA_W'(rd_word), MAX_DATA_W'(wr_data),
                                       MAX_BE_W'(wr_be)));
      end
`endif
    end
  end

  // Stage 1 valid bit, discarded on reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) s1_valid_q <= 1'b0;
    else     s1_valid_q <= s1_valid_d;
  end

  // Stage 1 data register, no reset needed behind the valid bit
  always_ff @(posedge CLK) begin
    s1_data_q <= s1_data_d;
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              s2_valid_d, s2_valid_q;
      logic [DATA_W-1:0] s2_data_d, s2_data_q;
`ifdef BRAM_SDP_FWD_EN
      logic [ADDR_W-1:0] s1_addr_d, s1_addr_q;
      logic              wr_hit_s1;

      // Remember the stage-1 address so a write one cycle later can be merged
      always_comb begin
        s1_addr_d = fire ? rd_req_addr : s1_addr_q;
      end

      // Stage 1 address register
      always_ff @(posedge CLK) begin
        s1_addr_q <= s1_addr_d;
      end

      assign wr_hit_s1 = s1_valid_q && wr_en && wr_in_range && (wr_addr == s1_addr_q);
`endif

      // Stage 2: extra output register
      always_comb begin
        s2_valid_d = s1_valid_q;
        s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
`ifdef BRAM_SDP_FWD_EN
        if (wr_hit_s1) begin
          s2_data_d = DATA_W'(byte_merge(MAX_DATA_W'(s1_data_q), MAX_DATA_W'(wr_data),
                                         MAX_BE_W'(wr_be)));
        end
`endif
      end

      // Stage 2 valid bit, discarded on reset
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) s2_valid_q <= 1'b0;
        else     s2_valid_q <= s2_valid_d;
      end

      // Stage 2 data register
      always_ff @(posedge CLK) begin
        s2_data_q <= s2_data_d;
      end

      assign push_valid = s2_valid_q;
      assign push_data  = s2_data_q;
    end else begin : g_no_out_reg
      assign push_valid = s1_valid_q;
      assign push_data  = s1_data_q;
    end
  endgenerate

  bram_sdp_rsp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push_valid),
    .push_data (push_data),
    .pop       (rd_rsp_ready),
    .out_valid (rd_rsp_valid),
    .out_data  (rd_rsp_data)
  );

  // Credits cover in-flight reads plus buffered responses, so the FIFO never overflows
  always_comb begin
    credit_d = credit_q;
    if (fire && !pop) credit_d = credit_q + CREDIT_W'(1);
    else if (!fire && pop) credit_d = credit_q - CREDIT_W'(1);
  end

  // Credit counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) credit_q <= '0;
    else     credit_q <= credit_d;
  end

endmodule
